// File: rtl/store_commit_unit.sv
// Store commit unit: formats committed stores into word writes, queues them and drives the cache write port.
// Optional macro STORE_COMMIT_BYPASS_EN lets a store reach the cache port in its accept cycle when the queue is idle.
module store_commit_unit #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_write_to_cache,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_funct3,
    output logic        out_cache_stall,
    output logic        out_cache_req,
    output logic [31:0] out_cache_addr,
    output logic [31:0] out_cache_wdata,
    output logic [3:0]  out_cache_byte_en,
    input  logic        in_cache_ack,
    input  logic        in_cache_hit,
    output logic        out_fill_req,
    input  logic        in_fill_done,
    output logic        out_store_fault,
    output logic [31:0] out_fault_addr,
    output logic        out_drained
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t         state;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [29:0]    mem_addr  [FIFO_DEPTH];
    logic [31:0]    mem_wdata [FIFO_DEPTH];
    logic [3:0]     mem_be    [FIFO_DEPTH];

    logic           fmt_ok;
    logic [3:0]     fmt_be;
    logic [31:0]    fmt_wdata;
    logic           accept;
    logic           empty;
    logic           bypass;
    logic           req_valid;
    logic [31:0]    sel_addr;
    logic [31:0]    sel_wdata;
    logic [3:0]     sel_be;
    logic           hit_ack;
    logic           miss_ack;
    logic           push;
    logic           pop;
    logic           store_fault;
    logic [31:0]    fault_addr;

    always_comb begin
        fmt_ok    = 1'b0;
        fmt_be    = '0;
        fmt_wdata = '0;
        case (in_funct3)
            3'b000: begin
                fmt_ok    = 1'b1;
                fmt_be    = 4'b0001 << in_addr[1:0];
                fmt_wdata = {4{in_data[7:0]}};
            end
            3'b001: begin
                fmt_ok    = ~in_addr[0];
                fmt_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                fmt_wdata = {2{in_data[15:0]}};
            end
            3'b010: begin
                fmt_ok    = (in_addr[1:0] == 2'b00);
                fmt_be    = 4'b1111;
                fmt_wdata = in_data;
            end
            default: ;
        endcase
    end

    assign out_cache_stall = (count == CW'(FIFO_DEPTH));
    assign empty           = (count == '0);
    assign accept          = in_write_to_cache & ~out_cache_stall;

`ifdef STORE_COMMIT_BYPASS_EN
    assign bypass = accept & fmt_ok & empty & (state == RUN);
`else
    assign bypass = 1'b0;
`endif

    assign req_valid = (state == RUN) & (~empty | bypass);
    assign sel_addr  = bypass ? {in_addr[31:2], 2'b00} : {mem_addr[rd_ptr], 2'b00};
    assign sel_wdata = bypass ? fmt_wdata : mem_wdata[rd_ptr];
    assign sel_be    = bypass ? fmt_be : mem_be[rd_ptr];

    assign hit_ack  = req_valid & in_cache_ack & in_cache_hit;
    assign miss_ack = req_valid & in_cache_ack & ~in_cache_hit;
    // A bypassed store that is written immediately never occupies an entry.
    assign pop      = hit_ack & ~bypass;
    assign push     = accept & fmt_ok & ~(bypass & hit_ack);

    assign out_cache_req     = req_valid;
    assign out_cache_addr    = req_valid ? sel_addr  : '0;
    assign out_cache_wdata   = req_valid ? sel_wdata : '0;
    assign out_cache_byte_en = req_valid ? sel_be    : '0;
    assign out_fill_req      = (state == MISS);
    assign out_store_fault   = store_fault;
    assign out_fault_addr    = fault_addr;
    assign out_drained       = empty & (state == RUN) & ~in_write_to_cache;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]  <= in_addr[31:2];
            mem_wdata[wr_ptr] <= fmt_wdata;
            mem_be[wr_ptr]    <= fmt_be;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            store_fault <= 1'b0;
            fault_addr  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count       <= count + CW'(push) - CW'(pop);
            store_fault <= accept & ~fmt_ok;
            if (accept & ~fmt_ok) fault_addr <= in_addr;
            case (state)
                RUN:     if (miss_ack) state <= MISS;
                MISS:    if (in_fill_done) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_store_commit_unit.sv
// Scoreboard bench for store_commit_unit: expected cache writes are queued at accept and checked at each hit.
module tb_store_commit_unit;

    logic        clk;
    logic        reset;
    logic        in_write_to_cache;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [2:0]  in_funct3;
    logic        out_cache_stall;
    logic        out_cache_req;
    logic [31:0] out_cache_addr;
    logic [31:0] out_cache_wdata;
    logic [3:0]  out_cache_byte_en;
    logic        in_cache_ack;
    logic        in_cache_hit;
    logic        out_fill_req;
    logic        in_fill_done;
    logic        out_store_fault;
    logic [31:0] out_fault_addr;
    logic        out_drained;

    int passed = 0;
    int total = 0;
    int grants = 0;
    int stall_waits = 0;
    logic [67:0] sb[$];

    store_commit_unit #(.FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .in_write_to_cache(in_write_to_cache),
        .in_addr(in_addr),
        .in_data(in_data),
        .in_funct3(in_funct3),
        .out_cache_stall(out_cache_stall),
        .out_cache_req(out_cache_req),
        .out_cache_addr(out_cache_addr),
        .out_cache_wdata(out_cache_wdata),
        .out_cache_byte_en(out_cache_byte_en),
        .in_cache_ack(in_cache_ack),
        .in_cache_hit(in_cache_hit),
        .out_fill_req(out_fill_req),
        .in_fill_done(in_fill_done),
        .out_store_fault(out_store_fault),
        .out_fault_addr(out_fault_addr),
        .out_drained(out_drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sampled shortly after the falling edge so same-edge scoreboard pushes land first.
    always @(negedge clk) begin
        #2;
        if (out_cache_req && in_cache_ack && in_cache_hit) begin
            logic [67:0] exp_w;
            grants++;
            total++;
            if (sb.size() == 0) begin
                $display("FAIL cache_write: unexpected write addr=%h wdata=%h be=%b, none queued",
                         out_cache_addr, out_cache_wdata, out_cache_byte_en);
            end else begin
                exp_w = sb.pop_front();
                if ({out_cache_addr, out_cache_wdata, out_cache_byte_en} !== exp_w)
                    $display("FAIL cache_write: got addr=%h wdata=%h be=%b, want addr=%h wdata=%h be=%b",
                             out_cache_addr, out_cache_wdata, out_cache_byte_en,
                             exp_w[67:36], exp_w[35:4], exp_w[3:0]);
                else
                    passed++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [67:0] model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        case (f)
            3'b000: model = {wa, {4{d[7:0]}}, 4'(1 << a[1:0])};
            3'b001: model = {wa, {2{d[15:0]}}, (a[1] ? 4'b1100 : 4'b0011)};
            default: model = {wa, d, 4'b1111};
        endcase
    endfunction

    task automatic commit(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                          input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] eb);
        int n;
        in_write_to_cache = 1'b1;
        in_addr = a;
        in_data = d;
        in_funct3 = f;
        n = 0;
        @(negedge clk);
        while (out_cache_stall && n < 100) begin
            n++;
            stall_waits++;
            @(negedge clk);
        end
        if (n >= 100) begin
            total++;
            $display("FAIL commit_timeout: stall=%b held, want 0 within 100 cycles", out_cache_stall);
        end else begin
            sb.push_back({ea, ew, eb});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_write_to_cache = 1'b0;
        in_addr = '0;
        in_data = '0;
        in_funct3 = '0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sb.size() == 0 && out_drained === 1'b1) && n < 50) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n >= 50)
            $display("FAIL %s_drain: pending=%0d drained=%b, want 0 and 1", name, sb.size(), out_drained);
        else
            passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({out_cache_req, out_fill_req, out_store_fault, out_cache_stall, out_drained} !== 5'b00001)
            $display("FAIL reset_ctrl: req/fill/fault/stall/drained=%b, want 00001",
                     {out_cache_req, out_fill_req, out_store_fault, out_cache_stall, out_drained});
        else
            passed++;
        total++;
        if ({out_cache_addr, out_cache_wdata, out_cache_byte_en, out_fault_addr} !== '0)
            $display("FAIL reset_data: addr=%h wdata=%h be=%b faddr=%h, want all 0",
                     out_cache_addr, out_cache_wdata, out_cache_byte_en, out_fault_addr);
        else
            passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_sb();
        int g0;
        in_cache_ack = 1'b1;
        in_cache_hit = 1'b1;
        g0 = grants;
        commit(32'h1003, 32'h0000_00AB, 3'b000, 32'h1000, 32'hABAB_ABAB, 4'b1000);
        idle();
        @(negedge clk);
`ifndef STORE_COMMIT_BYPASS_EN
        total++;
        if (out_cache_req !== 1'b1 || out_drained !== 1'b0)
            $display("FAIL sb_latency: req=%b drained=%b, want 1 0", out_cache_req, out_drained);
        else
            passed++;
`endif
        @(posedge clk);
        #1;
        wait_drain("sb");
        total++;
        if (grants - g0 !== 1)
            $display("FAIL sb_count: writes=%0d, want 1", grants - g0);
        else
            passed++;
    endtask

    task automatic test_fault(input logic [31:0] a, input logic [2:0] f);
        int g0;
        in_cache_ack = 1'b1;
        in_cache_hit = 1'b1;
        g0 = grants;
        in_write_to_cache = 1'b1;
        in_addr = a;
        in_data = 32'hFFFF_FFFF;
        in_funct3 = f;
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        total++;
        if (out_store_fault !== 1'b1 || out_fault_addr !== a)
            $display("FAIL fault_pulse: fault=%b faddr=%h, want 1 %h", out_store_fault, out_fault_addr, a);
        else
            passed++;
        total++;
        if (out_cache_req !== 1'b0)
            $display("FAIL fault_noreq: req=%b, want 0", out_cache_req);
        else
            passed++;
        @(negedge clk);
        total++;
        if (out_store_fault !== 1'b0)
            $display("FAIL fault_width: fault=%b one cycle later, want 0", out_store_fault);
        else
            passed++;
        total++;
        if (grants - g0 !== 0)
            $display("FAIL fault_nowrite: writes=%0d, want 0", grants - g0);
        else
            passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int g0;
        logic [31:0] d;
        in_cache_ack = 1'b0;
        in_cache_hit = 1'b1;
        g0 = grants;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            commit(32'h4000 + 32'(4 * i), d, 3'b010, 32'h4000 + 32'(4 * i), d, 4'b1111);
            total++;
            if (out_cache_stall !== (i == 3))
                $display("FAIL stall_level: after accept %0d stall=%b, want %b", i + 1, out_cache_stall, i == 3);
            else
                passed++;
        end
        d = $urandom;
        fork
            commit(32'h4010, d, 3'b010, 32'h4010, d, 4'b1111);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    total++;
                    if (out_cache_stall !== 1'b1 || sb.size() !== 4)
                        $display("FAIL stall_hold: stall=%b pending=%0d, want 1 4", out_cache_stall, sb.size());
                    else
                        passed++;
                end
                in_cache_ack = 1'b1;
            end
        join
        idle();
        wait_drain("stall");
        total++;
        if (grants - g0 !== 5)
            $display("FAIL stall_count: writes=%0d, want 5", grants - g0);
        else
            passed++;
    endtask

    task automatic test_miss();
        in_cache_ack = 1'b0;
        in_cache_hit = 1'b0;
        in_fill_done = 1'b0;
        commit(32'h3002, 32'h0000_1234, 3'b001, 32'h3000, 32'h1234_1234, 4'b1100);
        idle();
        @(negedge clk);
        total++;
        if ({out_cache_req, out_cache_addr, out_cache_wdata, out_cache_byte_en} !== {1'b1, 32'h3000, 32'h1234_1234, 4'b1100})
            $display("FAIL miss_first: req=%b addr=%h wdata=%h be=%b, want 1 00003000 12341234 1100",
                     out_cache_req, out_cache_addr, out_cache_wdata, out_cache_byte_en);
        else
            passed++;
        in_cache_ack = 1'b1;
        @(posedge clk);
        #1;
        in_cache_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (out_fill_req !== 1'b1 || out_cache_req !== 1'b0)
                $display("FAIL miss_fill: fill=%b req=%b, want 1 0", out_fill_req, out_cache_req);
            else
                passed++;
        end
        in_fill_done = 1'b1;
        @(posedge clk);
        #1;
        in_fill_done = 1'b0;
        @(negedge clk);
        total++;
        if ({out_fill_req, out_cache_req, out_cache_addr, out_cache_wdata, out_cache_byte_en} !==
            {1'b0, 1'b1, 32'h3000, 32'h1234_1234, 4'b1100})
            $display("FAIL miss_reissue: fill=%b req=%b addr=%h wdata=%h be=%b, want 0 1 00003000 12341234 1100",
                     out_fill_req, out_cache_req, out_cache_addr, out_cache_wdata, out_cache_byte_en);
        else
            passed++;
        in_cache_ack = 1'b1;
        in_cache_hit = 1'b1;
        @(posedge clk);
        #1;
        wait_drain("miss");
    endtask

    task automatic test_reset_mid();
        int g0;
        in_cache_ack = 1'b0;
        in_cache_hit = 1'b0;
        for (int i = 0; i < 3; i++)
            commit(32'h5000 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010, 32'h5000 + 32'(4 * i), 32'hA0 + 32'(i), 4'b1111);
        idle();
        @(negedge clk);
        in_cache_ack = 1'b1;
        @(posedge clk);
        #1;
        in_cache_ack = 1'b0;
        @(negedge clk);
        total++;
        if (out_fill_req !== 1'b1)
            $display("FAIL rstmid_miss: fill=%b, want 1", out_fill_req);
        else
            passed++;
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({out_cache_req, out_fill_req, out_cache_stall, out_store_fault, out_drained} !== 5'b00001 ||
            {out_cache_addr, out_cache_wdata, out_cache_byte_en} !== '0)
            $display("FAIL rstmid_clear: req/fill/stall/fault/drained=%b addr=%h, want 00001 0",
                     {out_cache_req, out_fill_req, out_cache_stall, out_store_fault, out_drained}, out_cache_addr);
        else
            passed++;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_cache_ack = 1'b1;
        in_cache_hit = 1'b1;
        g0 = grants;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (out_cache_req !== 1'b0 || out_fill_req !== 1'b0)
                $display("FAIL rstmid_quiet: req=%b fill=%b, want 0 0", out_cache_req, out_fill_req);
            else
                passed++;
        end
        total++;
        if (grants - g0 !== 0)
            $display("FAIL rstmid_count: writes=%0d, want 0", grants - g0);
        else
            passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [8];
        logic [31:0] td [8];
        logic [2:0]  tf [8];
        logic [67:0] e;
        int g0;
        int s0;
        ta = '{32'h6000, 32'h6005, 32'h600A, 32'h600C, 32'h6010, 32'h6016, 32'h601C, 32'h6021};
        td = '{32'h1122_3344, 32'h0000_00C3, 32'h0000_BEEF, 32'hDEAD_BEEF,
               32'hFFFF_FF5A, 32'h1234_5678, 32'hCAFE_F00D, 32'h0000_0099};
        tf = '{3'b010, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000};
        in_cache_ack = 1'b1;
        in_cache_hit = 1'b1;
        g0 = grants;
        s0 = stall_waits;
        for (int i = 0; i < 8; i++) begin
            e = model(ta[i], td[i], tf[i]);
            commit(ta[i], td[i], tf[i], e[67:36], e[35:4], e[3:0]);
        end
        idle();
        wait_drain("b2b");
        total++;
        if (grants - g0 !== 8 || stall_waits - s0 !== 0)
            $display("FAIL b2b_rate: writes=%0d stall_waits=%0d, want 8 0", grants - g0, stall_waits - s0);
        else
            passed++;
    endtask

`ifdef STORE_COMMIT_BYPASS_EN
    task automatic test_bypass();
        int g0;
        in_cache_ack = 1'b1;
        in_cache_hit = 1'b1;
        g0 = grants;
        commit(32'h7000, 32'h5555_AAAA, 3'b010, 32'h7000, 32'h5555_AAAA, 4'b1111);
        total++;
        if (grants - g0 !== 1)
            $display("FAIL bypass_zero_latency: writes in commit cycle=%0d, want 1", grants - g0);
        else
            passed++;
        idle();
        wait_drain("bypass");
    endtask
`endif

    initial begin
        reset = 1'b1;
        in_cache_ack = 1'b0;
        in_cache_hit = 1'b0;
        in_fill_done = 1'b0;
        idle();
        test_reset();
        test_sb();
        test_fault(32'h2002, 3'b010);
        test_fault(32'h2001, 3'b001);
        test_fault(32'h2000, 3'b011);
        test_stall();
        test_miss();
        test_back_to_back();
`ifdef STORE_COMMIT_BYPASS_EN
        test_bypass();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
